// File: rtl/byte_stream_mux_pkg.sv
// byte_stream_mux_pkg: shared types and helpers for byte_stream_mux.
//   state_t    - arbiter/burst state (IDLE, BURST)
//   MODE_FIXED - mode encoding for fixed channel select
//   MODE_RR    - mode encoding for round-robin arbitration
//   sel_w()    - index width for an n-entry range, never below 1
package byte_stream_mux_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int unsigned sel_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/byte_stream_mux_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Returns the first set request bit at or after i_ptr, wrapping N-1 -> 0.
//   i_req   in  N   request bits
//   i_ptr   in  PW  search start index (must be < N)
//   o_idx   out PW  chosen index (0 when nothing found)
//   o_found out 1   at least one request was set
module rr_pick
  import byte_stream_mux_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = sel_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [PW-1:0] o_idx,
  output logic          o_found
);

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    int unsigned w_j;
    o_idx   = '0;
    o_found = 1'b0;
    w_j     = 0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      w_j = (32'(i_ptr) + 32'(k)) % N;
      if (i_req[w_j]) begin
        o_idx   = PW'(w_j);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/byte_stream_mux.sv
// byte_stream_mux: N_CH-to-1 burst multiplexer for byte streams.
// In IDLE a channel is granted (fixed select or round-robin); in BURST the
// granted channel streams BURST_LEN beats through a one-deep output register.
// Optional feature macro: BYTE_STREAM_MUX_PARITY_EN adds out_par (XOR of beat).
//   clk, rst            clock, synchronous active-high reset
//   in_data/in_valid    per-channel lanes, channel c at [c*DATA_W +: DATA_W]
//   in_ready            per-channel accept, only the granted bit in BURST
//   sel, mode           fixed select / mode, sampled only in IDLE
//   out_data/out_valid  registered output beat, out_ready downstream accept
//   out_ch              source channel of out_data
//   out_par             (optional) parity of out_data
module byte_stream_mux
  import byte_stream_mux_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned N_CH      = 4,
  parameter int unsigned BURST_LEN = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic [N_CH-1:0]          in_valid,
  output logic [N_CH-1:0]          in_ready,
  input  logic [sel_w(N_CH)-1:0]   sel,
  input  logic                     mode,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [sel_w(N_CH)-1:0]   out_ch
`ifdef BYTE_STREAM_MUX_PARITY_EN
  ,
  output logic                     out_par
`endif
);

  localparam int unsigned SW = sel_w(N_CH);
  localparam int unsigned CW = sel_w(BURST_LEN);

  state_t            r_state,     w_state_n;
  logic [SW-1:0]     r_grant,     w_grant_n;
  logic [SW-1:0]     r_rr_ptr,    w_rr_ptr_n;
  logic [CW-1:0]     r_cnt,       w_cnt_n;
  logic [DATA_W-1:0] r_out_data,  w_out_data_n;
  logic              r_out_valid, w_out_valid_n;
  logic [SW-1:0]     r_out_ch,    w_out_ch_n;
`ifdef BYTE_STREAM_MUX_PARITY_EN
  logic              r_out_par,   w_out_par_n;
`endif

  logic              w_accept;
  logic              w_slot_free;
  logic [DATA_W-1:0] w_lane;
  logic [SW-1:0]     w_rr_idx;
  logic              w_rr_found;

  rr_pick #(.N(N_CH), .PW(SW)) u_rr_pick (
    .i_req  (in_valid),
    .i_ptr  (r_rr_ptr),
    .o_idx  (w_rr_idx),
    .o_found(w_rr_found)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
`ifdef BYTE_STREAM_MUX_PARITY_EN
      r_out_par   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_n;
      r_grant     <= w_grant_n;
      r_rr_ptr    <= w_rr_ptr_n;
      r_cnt       <= w_cnt_n;
      r_out_data  <= w_out_data_n;
      r_out_valid <= w_out_valid_n;
      r_out_ch    <= w_out_ch_n;
`ifdef BYTE_STREAM_MUX_PARITY_EN
      r_out_par   <= w_out_par_n;
`endif
    end
  end

  // Arbitration, beat transfer and burst counting.
  always_comb begin
    w_state_n     = r_state;
    w_grant_n     = r_grant;
    w_rr_ptr_n    = r_rr_ptr;
    w_cnt_n       = r_cnt;
    w_out_data_n  = r_out_data;
    w_out_valid_n = r_out_valid;
    w_out_ch_n    = r_out_ch;
`ifdef BYTE_STREAM_MUX_PARITY_EN
    w_out_par_n   = r_out_par;
`endif
    in_ready      = '0;
    w_accept      = 1'b0;
    w_slot_free   = !r_out_valid || out_ready;
    w_lane        = in_data[32'(r_grant)*DATA_W +: DATA_W];

    case (r_state)
      IDLE: begin
        if (mode == MODE_FIXED) begin
          // Out-of-range select never grants.
          if ((32'(sel) < N_CH) && in_valid[sel]) begin
            w_grant_n = sel;
            w_state_n = BURST;
          end
        end else if (w_rr_found) begin
          w_grant_n = w_rr_idx;
          w_state_n = BURST;
        end
      end
      BURST: begin
        in_ready[r_grant] = w_slot_free;
        w_accept          = in_valid[r_grant] && w_slot_free;
        if (w_accept) begin
          w_out_data_n  = w_lane;
          w_out_ch_n    = r_grant;
          w_out_valid_n = 1'b1;
`ifdef BYTE_STREAM_MUX_PARITY_EN
          w_out_par_n   = ^w_lane;
`endif
          if (r_cnt == CW'(BURST_LEN - 1)) begin
            w_state_n  = IDLE;
            w_cnt_n    = '0;
            w_rr_ptr_n = (r_grant == SW'(N_CH - 1)) ? '0 : r_grant + SW'(1);
          end else begin
            w_cnt_n = r_cnt + CW'(1);
          end
        end
      end
      default: w_state_n = IDLE;
    endcase

    // Drained with nothing new behind it.
    if (!w_accept && out_ready) begin
      w_out_valid_n = 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_ch    = r_out_ch;
`ifdef BYTE_STREAM_MUX_PARITY_EN
  assign out_par   = r_out_par;
`endif

endmodule
